if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS CPU; sits directly upstream of the decoder/control unit.
//  Owns the PC and drives the instruction-memory request/response handshake.
//  Holds the fetched word in an instruction register (IR) and slices out op/func/rs/rt/rd/imm.
//  Advances the PC when decode/execute accepts: sequential, or branch target when branch & zero.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC value loaded on reset
//  FETCH_TIMEOUT 8              max cycles in FETCH without imem_valid before re-request (>=2)
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst_n        in   1   reset, synchronous, active-low
//  imem_req     out  1   fetch request, address valid
//  imem_addr    out  32  word-aligned fetch address (= pc)
//  imem_valid   in   1   response strobe; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  instr_valid  out  1   IR holds a valid instruction for decode
//  instr_ready  in   1   decode/execute consumes instruction this cycle
//  branch       in   1   from control: current instruction is beq
//  zero         in   1   from ALU: rs == rt
//  op           out  6   IR[31:26]
//  func         out  6   IR[5:0]
//  rs,rt,rd     out  5   IR[25:21], IR[20:16], IR[15:11]
//  imm          out  16  IR[15:0]
//  pc           out  32  address of instruction in IR
//  pc_plus4     out  32  pc + 4 (mod 2^32)
//  fetch_err    out  1   one-cycle pulse on fetch timeout
// BEHAVIOUR
//  Reset (rst_n=0 at edge): pc=RESET_PC, IR=0, state=FETCH, instr_valid=0, fetch_err=0, wait_cnt=0.
//   imem_req is 1 in the first cycle after reset release.
//  FSM states: FETCH, ISSUE.
//  FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
//   - imem_valid=1: IR<=imem_rdata, wait_cnt<=0, go to ISSUE.
//   - Otherwise wait_cnt++.
//   - wait_cnt==FETCH_TIMEOUT-1 without imem_valid: fetch_err pulses 1 cycle, wait_cnt<=0,
//     stay in FETCH with the same pc. imem_req drops to 0 for that one cycle (re-request).
//  ISSUE: imem_req=0, instr_valid=1; IR, pc and field outputs stay stable until accepted.
//   - instr_ready=1: pc <= (branch & zero) ? pc_plus4 + {{14{imm[15]}}, imm, 2'b00} : pc_plus4,
//     then go to FETCH.
//   - instr_ready=0: hold (stall), any duration.
//  branch/zero are sampled only in the accepting cycle; ignored elsewhere.
//  imem_valid outside FETCH is ignored; IR is never overwritten in ISSUE.
//  Latency: combinational memory (imem_valid in the request cycle) gives 2 cycles per instruction min.
//  Arithmetic: all PC math is 32-bit unsigned and wraps (pc 32'hFFFF_FFFC + 4 -> 0).
//   Negative offsets sign-extend correctly. pc[1:0] is always 00.
//  Reset mid-fetch or mid-issue: the reset wins. A response arriving in the reset cycle is discarded.
//  Outputs op/func/rs/rt/rd/imm are pure slices of IR (no extra latency).
// CONFIGURATION
//  IF_JUMP_EN defined: op==6'b000010 (j) is resolved locally.
//   - On accept, pc <= {pc_plus4[31:28], IR[25:0], 2'b00}; branch/zero are ignored for that word.
//   - Decode still sees the instruction (instr_valid=1) and must treat it as a no-op.
//  IF_JUMP_EN undefined: j is not special; pc follows the branch/sequential rule only.
// TESTING
//  1 Reset, combinational imem with mem[0]=32'h8C01_0004 -> cycle 1 imem_addr=0; cycle 2
//    instr_valid=1, op=6'h23, rt=1, imm=4.
//  2 Three words, instr_ready=1 always, branch=0 -> pc sequence 0,4,8, one instr per 2 cycles.
//  3 beq at pc=0x10, imm=16'hFFFC, branch=1, zero=1 -> next pc=0x04.
//    Same stimulus with zero=0 -> next pc=0x14.
//  4 instr_ready=0 for 5 cycles in ISSUE -> IR/pc/instr_valid unchanged; accept on cycle 6 -> FETCH.
//  5 imem_valid withheld 8 cycles (FETCH_TIMEOUT=8) -> fetch_err pulse, imem_req=0 one cycle,
//    re-request at the same pc; late valid then captured.
//  6 IF_JUMP_EN: j with target field 26'h0000_040 at pc=0x0 -> next pc=0x100.
//    Without the macro -> next pc=0x4.
//    Plus: rst_n=0 during FETCH with imem_valid=1 -> IR=0, pc=RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the MIPS CPU.
//
// Owns the PC and runs the instruction-memory request/response exchange. It
// captures the fetched word in the instruction register (IR) and presents it,
// already sliced into fields, to the decoder/control unit.
//
// Optional feature macro: IF_JUMP_EN. When it is defined, the stage resolves
// j (op == 6'b000010) itself. Decode still sees the word and treats it as a
// no-op.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   imem_req/addr      fetch request and word-aligned address (= pc)
//   imem_valid/rdata   response strobe and instruction word
//   instr_valid/ready  IR handshake towards decode/execute
//   branch, zero       beq indication and ALU equality, used only on accept
//   op/func/rs/rt/rd/imm  field slices of IR
//   pc, pc_plus4       address of the instruction in IR, and that address + 4
//   fetch_err          one-cycle pulse when a fetch times out
//   fsm_state          debug view of the FSM state (0 = FETCH, 1 = ISSUE)
//
// Handshakes:
//   instr_valid/instr_ready : a transfer happens on a rising edge where both
//     are 1. While instr_valid is 1, IR, pc and all field outputs are stable.
//   imem_req/imem_valid : imem_valid is honoured only while imem_req is 1.
//     A response that arrives while imem_req is 0 is ignored.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err,
  output logic        fsm_state
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  localparam int              CW       = $clog2(FETCH_TIMEOUT);
  localparam logic [CW-1:0]   WAIT_MAX = CW'(FETCH_TIMEOUT - 1);
  // Force word alignment even if the parameter is given a misaligned value.
  localparam logic [31:0]     PC_INIT  = {RESET_PC[31:2], 2'b00};

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
  logic [31:0]   seq_pc;
  logic [31:0]   next_pc;

  // Field slices and PC views
  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm      = ir_q[15:0];
  assign func     = ir_q[5:0];
  assign pc       = pc_q;
  assign seq_pc   = pc_q + 32'd4;
  assign pc_plus4 = seq_pc;

  // The cycle in which fetch_err is high is the re-request gap, so no
  // request is presented in that cycle.
  assign imem_req    = (state_q == S_FETCH) && !err_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign fetch_err   = err_q;
  assign fsm_state   = state_q;

  // PC of the next instruction, used only in the accepting cycle.
  always_comb begin
    next_pc = seq_pc;
`ifdef IF_JUMP_EN
    if (ir_q[31:26] == 6'b000010) begin
      next_pc = {seq_pc[31:28], ir_q[25:0], 2'b00};
    end else if (branch && zero) begin
      next_pc = seq_pc + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    end
`else
    if (branch && zero) begin
      next_pc = seq_pc + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (err_q) begin
          // Re-request gap: nothing is outstanding, so any response is dropped.
          wait_d = '0;
        end else if (imem_valid) begin
          ir_d    = imem_rdata;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else if (wait_q == WAIT_MAX) begin
          err_d  = 1'b1;
          wait_d = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= PC_INIT;
      ir_q    <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// The bench owns a small instruction memory and a reference model of the
// program counter. Each cycle is advanced on the falling edge. Outputs are
// checked first, and the inputs for the next rising edge are driven after.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam int          TO     = 8;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;
  logic        fsm_state;

  // Clock / reset block
  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .zero(zero),
    .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc(pc), .pc_plus4(pc_plus4),
    .fetch_err(fetch_err), .fsm_state(fsm_state)
  );

  // Scoreboard
  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [0:255];
  logic [31:0] exp_q[$];       // expected fetch addresses, pushed on accept
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: the address of the next instruction, computed from the
  // word and the branch/zero values presented in the accepting cycle.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic br, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
`ifdef IF_JUMP_EN
    if (word[31:26] == 6'b000010) return {seq[31:28], word[25:0], 2'b00};
`endif
    if (br && z) begin
      off = int'($signed(word[15:0])) * 4;
      return seq + 32'(off);
    end
    return seq;
  endfunction

  // Driver tasks. Each one is entered and left just after a falling edge.
  task automatic reset_dut();
    rst_n       = 1'b0;
    imem_valid  = 1'b1;            // this response must be discarded
    imem_rdata  = $urandom;
    instr_ready = 1'b1;
    branch      = 1'b1;
    zero        = 1'b1;
    @(negedge clk);
    chk("rst_pc", pc, RST_PC);
    chk("rst_ir", {op, rs, rt, imm}, 32'h0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd1);
    rst_n       = 1'b1;
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    exp_q.delete();
    exp_pc = RST_PC;
  endtask

  // The response is withheld for 'delay' requesting cycles. After TO of them
  // the DUT must signal a timeout and leave one cycle without a request.
  task automatic fetch(input int delay);
    int   left;
    int   cnt;
    logic retry;
    left  = delay;
    cnt   = 0;
    retry = 1'b0;
    if (exp_q.size() > 0) exp_pc = exp_q.pop_front();
    forever begin
      chk("fetch_instr_valid", 32'(instr_valid), 32'd0);
      chk("fetch_state", 32'(fsm_state), 32'd0);
      chk("fetch_addr", imem_addr, exp_pc);
      if (retry) begin
        chk("timeout_err", 32'(fetch_err), 32'd1);
        chk("timeout_req", 32'(imem_req), 32'd0);
        imem_valid = 1'b0;
        retry = 1'b0;
      end else begin
        chk("fetch_err_idle", 32'(fetch_err), 32'd0);
        chk("fetch_req", 32'(imem_req), 32'd1);
        if (left == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem[exp_pc[9:2]];
          exp_ir     = mem[exp_pc[9:2]];
          @(negedge clk);
          imem_valid = 1'b0;
          imem_rdata = $urandom;
          return;
        end
        imem_valid = 1'b0;
        imem_rdata = $urandom;
        left--;
        cnt++;
        if (cnt == TO) begin
          retry = 1'b1;
          cnt   = 0;
        end
      end
      @(negedge clk);
    end
  endtask

  // Hold the instruction for 'stall' cycles, then accept it with br/z.
  task automatic issue(input int stall, input logic br, input logic z);
    for (int i = 0; i <= stall; i++) begin
      chk("issue_valid", 32'(instr_valid), 32'd1);
      chk("issue_state", 32'(fsm_state), 32'd1);
      chk("issue_req", 32'(imem_req), 32'd0);
      chk("issue_err", 32'(fetch_err), 32'd0);
      chk("issue_pc", pc, exp_pc);
      chk("issue_pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("issue_op", 32'(op), 32'(exp_ir[31:26]));
      chk("issue_rs", 32'(rs), 32'(exp_ir[25:21]));
      chk("issue_rt", 32'(rt), 32'(exp_ir[20:16]));
      chk("issue_rd", 32'(rd), 32'(exp_ir[15:11]));
      chk("issue_imm", 32'(imm), 32'(exp_ir[15:0]));
      chk("issue_func", 32'(func), 32'(exp_ir[5:0]));
      // Responses during ISSUE must not disturb IR.
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      if (i < stall) begin
        instr_ready = 1'b0;
        branch      = 1'($urandom_range(0, 1));
        zero        = 1'($urandom_range(0, 1));
      end else begin
        instr_ready = 1'b1;
        branch      = br;
        zero        = z;
        exp_q.push_back(model_next(exp_pc, exp_ir, br, z));
      end
      @(negedge clk);
    end
    instr_ready = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    imem_valid  = 1'b0;
  endtask

  task automatic run_seq(input int n);
    for (int i = 0; i < n; i++) begin
      fetch(0);
      issue(0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP;
    repeat (2) @(negedge clk);

    // Load word at reset address, combinational memory
    mem[0] = 32'h8C01_0004;
    reset_dut();
    chk("t1_addr", imem_addr, 32'h0);
    fetch(0);
    chk("t1_valid", 32'(instr_valid), 32'd1);
    chk("t1_op", 32'(op), 32'h23);
    chk("t1_rt", 32'(rt), 32'd1);
    chk("t1_imm", 32'(imm), 32'd4);
    issue(0, 1'b0, 1'b0);

    // Sequential words: 0, 4, 8, one instruction per two cycles
    run_seq(2);
    chk("t2_pc_after3", imem_addr, 32'hC);

    // beq at 0x10 with imm -4: taken, then not taken
    mem[4] = 32'h1000_FFFC;
    fetch(0);
    issue(0, 1'b0, 1'b0);
    chk("t3_at_beq", imem_addr, 32'h10);
    fetch(0);
    issue(0, 1'b1, 1'b1);
    chk("t3_taken", imem_addr, 32'h4);
    run_seq(3);
    fetch(0);
    issue(0, 1'b1, 1'b0);
    chk("t3_not_taken", imem_addr, 32'h14);

    // Five stall cycles, accepted on the sixth
    fetch(0);
    issue(5, 1'b0, 1'b0);
    chk("t4_after_stall", imem_addr, 32'h18);

    // Timeout and re-request, then late responses
    fetch(TO);
    issue(0, 1'b0, 1'b0);
    fetch(TO + 3);
    issue(1, 1'b0, 1'b0);
    fetch(2 * TO + 1);
    issue(0, 1'b0, 1'b0);
    chk("t5_after_timeouts", imem_addr, 32'h24);

    // j with target field 0x40 at pc 0
    mem[0] = 32'h0800_0040;
    reset_dut();
    fetch(0);
    issue(0, 1'b0, 1'b0);
`ifdef IF_JUMP_EN
    chk("t6_jump", imem_addr, 32'h100);
`else
    chk("t6_jump", imem_addr, 32'h4);
`endif

    // Backward branch from 0 wraps to 0xFFFFFFFC; +4 from there wraps to 0
    mem[0]   = 32'h1000_FFFE;
    mem[255] = NOP;
    reset_dut();
    fetch(0);
    issue(0, 1'b1, 1'b1);
    chk("wrap_neg", imem_addr, 32'hFFFF_FFFC);
    fetch(0);
    issue(0, 1'b0, 1'b0);
    chk("wrap_pos", imem_addr, 32'h0);

    // Reset during FETCH with a response present, and during ISSUE
    reset_dut();
    fetch(1);
    reset_dut();
    fetch(0);
    issue(0, 1'b0, 1'b0);

    // Random programs, delays, stalls, branch outcomes and resets
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset_dut();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 39) == 0) reset_dut();
      if ($urandom_range(0, 7) == 0) fetch(int'($urandom_range(TO, 2 * TO + 2)));
      else fetch(int'($urandom_range(0, 3)));
      issue(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    fetch(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
